// File: rtl/ctrl_pipe_param.sv
// Parametrised control-word pipeline: STAGES registers of {word, valid} with
// per-stage stall/flush and a condition-fail kill mask applied after KILL_STAGE.
module ctrl_pipe_param #(
    parameter int unsigned          WIDTH      = 21,
    parameter int unsigned          STAGES     = 4,
    parameter int unsigned          KILL_STAGE = 1,
    parameter logic [WIDTH-1:0]     KILL_MASK  = WIDTH'(21'h00B),
    parameter int unsigned          CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          in_word,
    input  logic                      in_valid,
    input  logic [STAGES-1:0]         stall,
    input  logic [STAGES-1:0]         flush,
    input  logic                      cond_ok,
    output logic [STAGES*WIDTH-1:0]   stage_word,
    output logic [STAGES-1:0]         stage_vld,
    output logic [WIDTH-1:0]          kill_word,
    output logic [CNT_W-1:0]          kill_cnt
);

    logic [STAGES-1:0][WIDTH-1:0] word_q, word_d;
    logic [STAGES-1:0]            vld_q, vld_d;
    logic [STAGES-1:0][WIDTH-1:0] src_word;
    logic [STAGES-1:0]            src_vld;
    logic                         kill_adv;

    always_comb begin
        kill_word = word_q[KILL_STAGE];
        if (vld_q[KILL_STAGE] && !cond_ok) begin
            kill_word = word_q[KILL_STAGE] & ~KILL_MASK;
        end
    end

    // A stage whose upstream neighbour is stalled takes a bubble so the held
    // word is not duplicated downstream.
    always_comb begin
        src_word    = '0;
        src_vld     = '0;
        src_word[0] = in_word;
        src_vld[0]  = in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            if (!stall[k-1]) begin
                src_word[k] = (k == KILL_STAGE + 1) ? kill_word : word_q[k-1];
                src_vld[k]  = vld_q[k-1];
            end
        end
    end

    always_comb begin
        word_d = word_q;
        vld_d  = vld_q;
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (flush[k]) begin
                word_d[k] = '0;
                vld_d[k]  = 1'b0;
            end else if (!stall[k]) begin
                word_d[k] = src_word[k];
                vld_d[k]  = src_vld[k];
            end
        end
    end

    assign kill_adv = !flush[KILL_STAGE+1] && !stall[KILL_STAGE+1] && !stall[KILL_STAGE]
                      && vld_q[KILL_STAGE] && !cond_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q   <= '0;
            vld_q    <= '0;
            kill_cnt <= '0;
        end else begin
            word_q <= word_d;
            vld_q  <= vld_d;
            if (kill_adv && (kill_cnt != '1)) begin
                kill_cnt <= kill_cnt + 1'b1;
            end
        end
    end

    assign stage_word = word_q;
    assign stage_vld  = vld_q;

endmodule
